// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate datapath: default widths and the
// accumulator FSM state encoding. Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
package mac_pkg;

    localparam int PROD_W  = 64;
    localparam int GUARD_W = 8;
    localparam int ACC_W   = PROD_W + GUARD_W;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t HOLD  = 2'd2;

endpackage

// File: rtl/acc_adder.sv
// Combinational W-bit ripple-carry adder in the style of the sixtyFourBitAdder,
// widened to the accumulator and exposing the carry-out for overflow detection.
module acc_adder #(
    parameter int W = mac_pkg::ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry_out
);
    import mac_pkg::*;

    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        carry_out = carry;
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of multiplier products behind a valid/ready handshake and
// presents the sum downstream. Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator #(
    parameter int PROD_W    = mac_pkg::PROD_W,
    parameter int GUARD_W   = mac_pkg::GUARD_W,
    parameter int MAX_TERMS = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PROD_W-1:0]             in_product,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PROD_W+GUARD_W-1:0]     acc_out,
    output logic [$clog2(MAX_TERMS):0]    term_count,
    output logic                          overflow
);
    import mac_pkg::*;

    localparam int SUM_W = PROD_W + GUARD_W;
    localparam int CNT_W = $clog2(MAX_TERMS) + 1;

    state_t             state;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   add_sum;
    logic [SUM_W-1:0]   acc_next;
    logic               carry;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               ovf;
    logic               accept;
    logic               reach_max;

    acc_adder #(.W(SUM_W)) u_acc_adder (
        .a         (acc),
        .b         ({{GUARD_W{1'b0}}, in_product}),
        .sum       (add_sum),
        .carry_out (carry)
    );

    assign in_ready   = (state != HOLD);
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready && !clear;
    assign count_next = count + CNT_W'(1);
    assign reach_max  = (count_next == CNT_W'(MAX_TERMS));

    // Saturating builds pin the sum at all-ones for the rest of the sequence once it overflows.
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    assign acc_next = (carry || ovf) ? '1 : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                state <= IDLE;
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end else if (accept) begin
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf | carry;
            state <= (in_last || reach_max) ? HOLD : ACCUM;
        end
    end

    assign acc_out    = acc;
    assign term_count = count;
    assign overflow   = ovf;

endmodule
